// File: rtl/load_strobe_ctrl.sv
// load_strobe_ctrl: per-channel sync/debounce/edge-qualified load strobes with shared index, collision and count
module load_strobe_ctrl #(
    parameter int NCH = 4,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W = 8,
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   ready_in,
    input  logic             clr_collision,
    output logic [NCH-1:0]   load_pulse,
    output logic [NCH-1:0]   held,
    output logic [NCH-1:0]   load_n,
    output logic             ch_valid,
    output logic [IDX_W-1:0] ch_idx,
    output logic             collision,
    output logic [CNT_W-1:0] load_count
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(NCH + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] DB = CW'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, QUAL, HELD, REL} state_e;

    state_e          st [NCH];
    logic [CW-1:0]   cnt [NCH];
    logic [NCH-1:0]  sync1, sync;
    logic [PW-1:0]   pc;
    logic [IDX_W-1:0] lo;

    assign load_n = ~held;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync <= '0;
            load_pulse <= '0;
            held <= '0;
            for (int i = 0; i < NCH; i++) begin
                st[i] <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= ready_in;
            sync <= sync1;
            for (int i = 0; i < NCH; i++) begin
                load_pulse[i] <= 1'b0;
                case (st[i])
                    IDLE: if (sync[i]) begin
                        if (DEBOUNCE == 1) begin
                            st[i] <= HELD;
                            load_pulse[i] <= 1'b1;
                            held[i] <= 1'b1;
                        end else begin
                            st[i] <= QUAL;
                            cnt[i] <= ONE;
                        end
                    end
                    QUAL: if (!sync[i]) begin
                        st[i] <= IDLE;
                        cnt[i] <= '0;
                    end else if (cnt[i] + ONE == DB) begin
                        st[i] <= HELD;
                        cnt[i] <= '0;
                        load_pulse[i] <= 1'b1;
                        held[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + ONE;
                    end
                    HELD: if (!sync[i]) begin
                        if (DEBOUNCE == 1) begin
                            st[i] <= IDLE;
                            held[i] <= 1'b0;
                        end else begin
                            st[i] <= REL;
                            cnt[i] <= ONE;
                        end
                    end
                    REL: if (sync[i]) begin
                        st[i] <= HELD;
                        cnt[i] <= '0;
                    end else if (cnt[i] + ONE == DB) begin
                        st[i] <= IDLE;
                        cnt[i] <= '0;
                        held[i] <= 1'b0;
                    end else begin
                        cnt[i] <= cnt[i] + ONE;
                    end
                    default: st[i] <= IDLE;
                endcase
            end
        end
    end

    // scan high to low so the last hit is the lowest pulsing channel
    always_comb begin
        pc = '0;
        lo = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            pc = pc + PW'(load_pulse[i]);
            if (load_pulse[i]) lo = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_valid <= 1'b0;
            ch_idx <= '0;
            collision <= 1'b0;
            load_count <= '0;
        end else begin
            ch_valid <= |load_pulse;
            ch_idx <= (|load_pulse) ? lo : ch_idx;
            collision <= (pc >= PW'(2)) | (collision & ~clr_collision);
            load_count <= load_count + CNT_W'(pc);
        end
    end
endmodule

// File: tb/tb_load_strobe_ctrl.sv
// tb_load_strobe_ctrl: table vectors, hand corner sequences and random stimulus against a run-length model
module tb_load_strobe_ctrl;
    localparam int NCH = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] ready_in = '0;
    logic       clr_collision = 1'b0;
    logic [3:0] load_pulse, held, load_n;
    logic       ch_valid;
    logic [1:0] ch_idx;
    logic       collision;
    logic [7:0] load_count;

    load_strobe_ctrl dut (
        .clk(clk), .reset(reset), .ready_in(ready_in), .clr_collision(clr_collision),
        .load_pulse(load_pulse), .held(held), .load_n(load_n), .ch_valid(ch_valid),
        .ch_idx(ch_idx), .collision(collision), .load_count(load_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model: debounced level plus length of the current opposing run
    logic [3:0] m_s1, m_s2, m_pulse, m_held, m_d;
    int         m_r [NCH];
    logic       m_valid, m_coll;
    int         m_idx, m_count;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_pulse = '0; m_held = '0; m_d = '0;
        for (int i = 0; i < NCH; i++) m_r[i] = 0;
        m_valid = 0; m_coll = 0; m_idx = 0; m_count = 0;
    endtask

    task automatic model_edge();
        logic [3:0] old;
        int n;
        old = m_pulse;
        for (int i = 0; i < NCH; i++) begin
            m_pulse[i] = 1'b0;
            if (m_s2[i] != m_d[i]) begin
                m_r[i]++;
                if (m_r[i] == D) begin
                    m_d[i] = m_s2[i];
                    m_r[i] = 0;
                    m_pulse[i] = m_s2[i];
                end
            end else m_r[i] = 0;
        end
        m_held = m_d;
        n = $countones(old);
        m_valid = n > 0;
        for (int i = NCH - 1; i >= 0; i--) if (old[i]) m_idx = i;
        m_coll = (n >= 2) || (m_coll && !clr_collision);
        m_count = (m_count + n) % 256;
        m_s2 = m_s1;
        m_s1 = ready_in;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        tests++;
        if (load_pulse !== m_pulse || held !== m_held || load_n !== ~m_held || ch_valid !== m_valid ||
            ch_idx !== 2'(m_idx) || collision !== m_coll || load_count !== 8'(m_count)) begin
            fails++;
            $display("FAIL %s: got p=%h h=%h ln=%h v=%b i=%0d c=%b n=%0d expected p=%h h=%h v=%b i=%0d c=%b n=%0d",
                     name, load_pulse, held, load_n, ch_valid, ch_idx, collision, load_count,
                     m_pulse, m_held, m_valid, m_idx, m_coll, m_count);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (!reset) model_reset(); else model_edge();
            @(negedge clk);
            chk_model("model");
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        #1;
        model_reset();
        chk_model("async_reset");
        #4;
        tick(cycles);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0] rdy;
        logic       clr;
        int         n;
        logic [3:0] eheld;
        int         ecount;
        logic       ecoll;
        int         eidx;
    } vec_t;

    vec_t vt [11];

    initial begin
        vt[0]  = '{4'b0100, 1'b0, 20, 4'b0100, 1, 1'b0, 2};
        vt[1]  = '{4'b0000, 1'b0, 4,  4'b0100, 1, 1'b0, 2};
        vt[2]  = '{4'b0000, 1'b0, 2,  4'b0000, 1, 1'b0, 2};
        vt[3]  = '{4'b0010, 1'b0, 3,  4'b0000, 1, 1'b0, 2};
        vt[4]  = '{4'b0000, 1'b0, 10, 4'b0000, 1, 1'b0, 2};
        vt[5]  = '{4'b0010, 1'b0, 20, 4'b0010, 2, 1'b0, 1};
        vt[6]  = '{4'b0000, 1'b0, 3,  4'b0010, 2, 1'b0, 1};
        vt[7]  = '{4'b0010, 1'b0, 10, 4'b0010, 2, 1'b0, 1};
        vt[8]  = '{4'b0000, 1'b0, 10, 4'b0000, 2, 1'b0, 1};
        vt[9]  = '{4'b1010, 1'b0, 20, 4'b1010, 4, 1'b1, 1};
        vt[10] = '{4'b1010, 1'b1, 1,  4'b1010, 4, 1'b0, 1};

        model_reset();
        // reset held with all ready lines high
        ready_in = 4'hF;
        @(negedge clk);
        do_reset(3);
        chk("rst_pulse", load_pulse, 0);
        chk("rst_held", held, 0);
        chk("rst_load_n", load_n, 4'hF);
        chk("rst_valid", ch_valid, 0);
        chk("rst_count", load_count, 0);
        chk("rst_coll", collision, 0);
        tick(5);
        chk("e4_no_pulse", load_pulse, 0);
        tick(1);
        chk("e5_pulse", load_pulse, 4'hF);
        chk("e5_held", held, 4'hF);
        tick(1);
        chk("e6_pulse_gone", load_pulse, 0);
        chk("e6_coll", collision, 1);
        chk("e6_count", load_count, 4);
        chk("e6_valid", ch_valid, 1);
        chk("e6_idx", ch_idx, 0);
        ready_in = 4'h0;
        tick(10);
        chk("all_released", held, 0);
        do_reset(2);

        for (int v = 0; v < 11; v++) begin
            ready_in = vt[v].rdy;
            clr_collision = vt[v].clr;
            tick(vt[v].n);
            chk($sformatf("vec%0d_held", v), held, vt[v].eheld);
            chk($sformatf("vec%0d_count", v), load_count, vt[v].ecount);
            chk($sformatf("vec%0d_coll", v), collision, vt[v].ecoll);
            chk($sformatf("vec%0d_idx", v), ch_idx, vt[v].eidx);
        end
        clr_collision = 1'b0;
        ready_in = 4'h0;
        tick(10);

        // reset while channel 0 is qualifying, then during its pulse cycle
        ready_in = 4'b0001;
        tick(4);
        do_reset(2);
        chk("midq_held", held, 0);
        tick(5);
        chk("requal_no_pulse", load_pulse, 0);
        tick(1);
        chk("requal_pulse", load_pulse, 1);
        do_reset(2);
        chk("midp_pulse_cleared", load_pulse, 0);
        chk("midp_count", load_count, 0);
        tick(6);
        chk("requal2_pulse", load_pulse, 1);
        tick(1);
        chk("requal2_count", load_count, 1);
        ready_in = 4'h0;
        tick(10);

        // counter wrap
        do_reset(1);
        for (int p = 0; p < 257; p++) begin
            ready_in = 4'b0001;
            tick(8);
            ready_in = 4'b0000;
            tick(8);
            if (p == 254) chk("count_255", load_count, 255);
        end
        chk("count_wrap", load_count, 1);

        // random runs on every channel
        begin
            int rem [NCH];
            for (int i = 0; i < NCH; i++) rem[i] = $urandom_range(1, 7);
            for (int c = 0; c < 3000; c++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (--rem[i] == 0) begin
                        ready_in[i] = ~ready_in[i];
                        rem[i] = $urandom_range(1, 7);
                    end
                end
                clr_collision = ($urandom_range(0, 7) == 0);
                tick(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
